// File: rtl/dcim_mc_seq.sv
// dcim_mc_seq: bit-serial sequencer driving NUM_COL column accumulators in lockstep.
// Takes a command over valid/ready, walks the input bits MSB-first, shift-accumulates
// the per-column partial sums, returns the result vector over valid/ready and keeps
// ping-pong weight-bank swaps out of an operation in progress.
// Optional feature macro: DCIM_OP_CNT_EN adds a saturating completed-operation counter (op_count).
module dcim_mc_seq #(
    parameter int NUM_COL     = 4,
    parameter int PSUM_WIDTH  = 12,
    parameter int MAX_IN_BITS = 16,
    parameter int ACC_WIDTH   = PSUM_WIDTH + MAX_IN_BITS
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             cmd_valid,
    output logic                             cmd_ready,
    input  logic [1:0]                       cmd_inwidth,
    input  logic                             cmd_signed,
    output logic [$clog2(MAX_IN_BITS)-1:0]   bit_sel,
    input  logic [NUM_COL*PSUM_WIDTH-1:0]    psum_in,
    output logic                             res_valid,
    input  logic                             res_ready,
    output logic [NUM_COL*ACC_WIDTH-1:0]     res_data,
    input  logic                             abort,
    input  logic                             swap_req,
    output logic                             mac_bank,
    output logic                             wr_bank,
    output logic                             swap_pending,
    output logic                             busy
`ifdef DCIM_OP_CNT_EN
    ,
    output logic [15:0]                      op_count
`endif
);

    localparam int CW = $clog2(MAX_IN_BITS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t                        state;
    state_t                        state_nxt;
    logic [CW-1:0]                 cnt;
    logic [CW-1:0]                 last_idx;
    logic                          is_signed;
    logic                          first;
    logic                          accept;
    logic                          handshake;
    logic signed [ACC_WIDTH-1:0]   acc [NUM_COL];
    logic signed [ACC_WIDTH-1:0]   psum_ext [NUM_COL];

    assign cmd_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign res_valid = (state == S_DONE);
    assign wr_bank   = ~mac_bank;
    assign bit_sel   = (state == S_RUN) ? cnt : '0;
    assign accept    = cmd_valid && cmd_ready && !abort;
    assign handshake = res_valid && res_ready && !abort;

    // Decode the requested width into the index of the first (MSB) bit; reserved code runs as 16 bits.
    always_comb begin
        last_idx = CW'(15);
        case (cmd_inwidth)
            2'b00:   last_idx = CW'(3);
            2'b01:   last_idx = CW'(7);
            default: last_idx = CW'(15);
        endcase
    end

    // Sign-extend each column's partial sum to accumulator width.
    always_comb begin
        for (int unsigned c = 0; c < NUM_COL; c++) begin
            psum_ext[c] = ACC_WIDTH'($signed(psum_in[c*PSUM_WIDTH +: PSUM_WIDTH]));
        end
    end

    // Pack the column accumulators into the result bus, column 0 in the LSBs.
    always_comb begin
        res_data = '0;
        for (int unsigned c = 0; c < NUM_COL; c++) begin
            res_data[c*ACC_WIDTH +: ACC_WIDTH] = acc[c];
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; abort overrides every other transition.
    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (cmd_valid) state_nxt = S_RUN;
                S_RUN:   if (cnt == '0) state_nxt = S_DONE;
                S_DONE:  if (res_ready) state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // Bit counter, signedness and first-bit flag for the current operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            is_signed <= 1'b0;
            first     <= 1'b0;
        end else if (abort) begin
            cnt   <= '0;
            first <= 1'b0;
        end else if (accept) begin
            cnt       <= last_idx;
            is_signed <= cmd_signed;
            first     <= 1'b1;
        end else if (state == S_RUN) begin
            first <= 1'b0;
            if (cnt != '0) cnt <= cnt - 1'b1;
        end
    end

    // Column accumulators: MSB of a signed input carries negative weight, so it loads the negated psum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned c = 0; c < NUM_COL; c++) acc[c] <= '0;
        end else if (abort || accept) begin
            for (int unsigned c = 0; c < NUM_COL; c++) acc[c] <= '0;
        end else if (state == S_RUN) begin
            for (int unsigned c = 0; c < NUM_COL; c++) begin
                if (first && is_signed) acc[c] <= -psum_ext[c];
                else                    acc[c] <= (acc[c] <<< 1) + psum_ext[c];
            end
        end
    end

    // Weight-bank swap: immediate when idle, otherwise deferred to the end of the operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mac_bank     <= 1'b0;
            swap_pending <= 1'b0;
        end else if (abort) begin
            if (swap_pending || swap_req) mac_bank <= ~mac_bank;
            swap_pending <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (swap_req) begin
                        if (accept) swap_pending <= 1'b1;
                        else        mac_bank     <= ~mac_bank;
                    end
                end
                S_RUN: begin
                    if (swap_req) swap_pending <= 1'b1;
                end
                S_DONE: begin
                    if (handshake) begin
                        if (swap_pending || swap_req) mac_bank <= ~mac_bank;
                        swap_pending <= 1'b0;
                    end else if (swap_req) begin
                        swap_pending <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef DCIM_OP_CNT_EN
    // Completed-operation counter, saturating; aborted operations are not counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                               op_count <= '0;
        else if (handshake && op_count != 16'hFFFF) op_count <= op_count + 16'd1;
    end
`endif

endmodule
